// File: rtl/m10k_stream_ctrl.sv
// ---------------------------------------------------------------------------
// m10k_stream_ctrl
//
// Store-then-forward frame buffer sequencer for one m10k_mem instance.
// A frame of `length` words is first written into the memory from the
// inbound valid/ready stream (FILL). It is then read back and sent out on a
// registered valid/ready stream with SOP/EOP framing (DRAIN). The block
// drives every memory address, write-enable and write-data signal itself.
//
// Build option:
//   M10K_STREAM_CTRL_PATTERN_EN  - when defined, FILL ignores the inbound
//                                  stream and writes wr_cnt as a counting
//                                  self-test pattern, one word per cycle.
//
// Ports:
//   clk, reset_n          single clock (also the memory wclk), async
//                         active-low reset
//   start, length         frame request and its length in words
//                         (0..2**ADDR_WIDTH), sampled when start is taken
//   busy, done            frame in progress / one-cycle completion pulse
//   snk_data/valid/ready  inbound stream (ready driven by this block)
//   src_data/valid/ready  outbound stream (data/valid registered)
//   src_sop, src_eop      first / last word markers, qualified by src_valid
//   mem_waddr/wdata/we    memory write port
//   mem_raddr, mem_rdata  memory read port, read data combinational
// ---------------------------------------------------------------------------
module m10k_stream_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] snk_data,
    input  logic                  snk_valid,
    output logic                  snk_ready,
    output logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_valid,
    input  logic                  src_ready,
    output logic                  src_sop,
    output logic                  src_eop,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Counters carry one extra bit so a full 2**ADDR_WIDTH frame never wraps.
    localparam int               CNT_W   = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  last_idx;
    logic              wr_beat;
    logic              out_free;
    logic              load;
    logic              last_accept;

    // Only meaningful while busy, where len is never zero.
    assign last_idx  = len - CNT_ONE;
    assign mem_waddr = wr_cnt[ADDR_WIDTH-1:0];
    assign mem_raddr = rd_cnt[ADDR_WIDTH-1:0];

`ifdef M10K_STREAM_CTRL_PATTERN_EN
    logic [DATA_WIDTH-1:0] pattern_word;

    generate
        if (DATA_WIDTH > CNT_W) begin : g_pat_ext
            assign pattern_word = {{(DATA_WIDTH-CNT_W){1'b0}}, wr_cnt};
        end else begin : g_pat_trunc
            assign pattern_word = wr_cnt[DATA_WIDTH-1:0];
        end
    endgenerate
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state is only ever updated with non-blocking
        // assignments so every register samples pre-edge values.
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // ------------------------------------------------------------------
    // Next state and combinational handshake / memory controls
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned and no latch is inferred.
        state_next  = state;
        snk_ready   = 1'b0;
        mem_we      = 1'b0;
        wr_beat     = 1'b0;
        load        = 1'b0;
        last_accept = 1'b0;
        out_free    = !src_valid || src_ready;
`ifdef M10K_STREAM_CTRL_PATTERN_EN
        mem_wdata   = pattern_word;
`else
        mem_wdata   = snk_data;
`endif

        unique case (state)
            IDLE: begin
                if (start && (length != '0)) state_next = FILL;
            end
            FILL: begin
`ifdef M10K_STREAM_CTRL_PATTERN_EN
                wr_beat   = 1'b1;
`else
                snk_ready = 1'b1;
                wr_beat   = snk_valid;
`endif
                mem_we = wr_beat;
                if (wr_beat && (wr_cnt == last_idx)) state_next = DRAIN;
            end
            DRAIN: begin
                load        = out_free && (rd_cnt < len);
                last_accept = src_valid && src_ready && src_eop;
                if (last_accept) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, output register, status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: all control state is reset; the frame store itself is
            // external memory and is deliberately left untouched.
            len       <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            src_data  <= '0;
            src_valid <= 1'b0;
            src_sop   <= 1'b0;
            src_eop   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            len    <= length;
                            wr_cnt <= '0;
                            busy   <= 1'b1;
                        end else begin
                            // Empty frame: complete immediately, never busy.
                            done <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (wr_beat) begin
                        wr_cnt <= wr_cnt + CNT_ONE;
                        if (wr_cnt == last_idx) rd_cnt <= '0;
                    end
                end
                DRAIN: begin
                    // Read data is combinational from rd_cnt, so the output
                    // register captures the word at the current address.
                    if (load) begin
                        src_data  <= mem_rdata;
                        src_valid <= 1'b1;
                        src_sop   <= (rd_cnt == '0);
                        src_eop   <= (rd_cnt == last_idx);
                        rd_cnt    <= rd_cnt + CNT_ONE;
                    end else if (out_free) begin
                        src_valid <= 1'b0;
                    end
                    if (last_accept) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_m10k_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_m10k_stream_ctrl
//
// Bench for m10k_stream_ctrl with a behavioural m10k memory (synchronous
// write, combinational read). A per-cycle vector table covers the basic
// frame, stalls on both streams, ignored start, zero and one word frames;
// hand-written sequences cover reset during DRAIN and a full-depth frame.
// With M10K_STREAM_CTRL_PATTERN_EN defined the counting pattern is checked
// instead of the inbound-stream tests.
// ---------------------------------------------------------------------------
module tb_m10k_stream_ctrl;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int CW = AW + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [CW-1:0] length;
    logic          busy;
    logic          done;
    logic [DW-1:0] snk_data;
    logic          snk_valid;
    logic          snk_ready;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_ready;
    logic          src_sop;
    logic          src_eop;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    m10k_stream_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .snk_data  (snk_data),
        .snk_valid (snk_valid),
        .snk_ready (snk_ready),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_sop   (src_sop),
        .src_eop   (src_eop),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    // Behavioural m10k: registered write, combinational read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
    assign mem_rdata = mem[mem_raddr];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One table row = one clock cycle: inputs held during the cycle and the
    // outputs expected in that same cycle.
    typedef struct {
        bit          start;
        bit [CW-1:0] length;
        bit          snk_valid;
        bit [DW-1:0] snk_data;
        bit          src_ready;
        bit          e_snk_ready;
        bit          e_we;
        bit          e_busy;
        bit          e_done;
        bit          e_valid;
        bit [DW-1:0] e_data;
        bit          e_sop;
        bit          e_eop;
    } vec_t;

    function automatic vec_t mk(input int st, input int len, input int sv, input int sd,
                                input int rdy, input int esr, input int ewe, input int eb,
                                input int ed, input int ev, input int edat, input int esop,
                                input int eeop);
        vec_t v;
        v.start       = st[0];
        v.length      = len[CW-1:0];
        v.snk_valid   = sv[0];
        v.snk_data    = sd[DW-1:0];
        v.src_ready   = rdy[0];
        v.e_snk_ready = esr[0];
        v.e_we        = ewe[0];
        v.e_busy      = eb[0];
        v.e_done      = ed[0];
        v.e_valid     = ev[0];
        v.e_data      = edat[DW-1:0];
        v.e_sop       = esop[0];
        v.e_eop       = eeop[0];
        return v;
    endfunction

    vec_t          tbl[$];
    logic [DW-1:0] exp_q[$];

    task automatic check_reset(input string tag);
        check({tag, " busy"},      busy,      0);
        check({tag, " done"},      done,      0);
        check({tag, " snk_ready"}, snk_ready, 0);
        check({tag, " src_valid"}, src_valid, 0);
        check({tag, " src_sop"},   src_sop,   0);
        check({tag, " src_eop"},   src_eop,   0);
        check({tag, " src_data"},  src_data,  0);
        check({tag, " mem_we"},    mem_we,    0);
        check({tag, " mem_waddr"}, mem_waddr, 0);
        check({tag, " mem_raddr"}, mem_raddr, 0);
    endtask

    // Starts a frame of exp_q.size() words and feeds exp_q back-to-back.
    // Returns at the falling edge of the first DRAIN cycle.
    task automatic fill_frame(input string tag);
        int n = exp_q.size();
        int aerr = 0;
        @(negedge clk);
        start  = 1'b1;
        length = CW'(n);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            snk_valid = 1'b1;
            snk_data  = exp_q[k];
            #1;
            if (mem_we !== 1'b1 || snk_ready !== 1'b1 || mem_waddr !== AW'(k)) aerr++;
            @(negedge clk);
        end
        snk_valid = 1'b0;
        check({tag, " fill addr/we errors"}, aerr, 0);
    endtask

    // Accepts beats with src_ready=1 until exp_q.size() beats arrive or the
    // cycle budget runs out, then checks the completion pulse.
    task automatic drain_frame(input string tag);
        int n = exp_q.size();
        int beats = 0, cyc = 0, first = -1, last = -1;
        int derr = 0, serr = 0, eerr = 0;
        src_ready = 1'b1;
        while (beats < n && cyc < 4 * n + 20) begin
            @(negedge clk);
            #1;
            cyc++;
            if (src_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                if (src_data !== exp_q[beats])      derr++;
                if (src_sop !== (beats == 0))       serr++;
                if (src_eop !== (beats == n - 1))   eerr++;
                beats++;
            end
        end
        check({tag, " beat count"},     beats,        n);
        check({tag, " data errors"},    derr,         0);
        check({tag, " sop errors"},     serr,         0);
        check({tag, " eop errors"},     eerr,         0);
        check({tag, " beat span"},      last - first, n - 1);
        @(negedge clk);
        #1;
        check({tag, " done pulse"},     done,      1);
        check({tag, " busy after"},     busy,      0);
        check({tag, " valid after"},    src_valid, 0);
        @(negedge clk);
        #1;
        check({tag, " done one cycle"}, done,      0);
        src_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        length    = '0;
        snk_valid = 1'b0;
        snk_data  = '0;
        src_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        reset_n = 1'b1;

`ifdef M10K_STREAM_CTRL_PATTERN_EN
        // Pattern FILL: inbound stream ignored, counting words written.
        @(negedge clk);
        start  = 1'b1;
        length = CW'(5);
        @(negedge clk);
        start     = 1'b0;
        snk_valid = 1'b1;
        snk_data  = 8'hEE;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("pat c%0d snk_ready", k), snk_ready, 0);
            check($sformatf("pat c%0d mem_we", k),    mem_we,    1);
            check($sformatf("pat c%0d mem_wdata", k), mem_wdata, k);
            check($sformatf("pat c%0d mem_waddr", k), mem_waddr, k);
            @(negedge clk);
        end
        snk_valid = 1'b0;
        #1;
        check("pat drain snk_ready", snk_ready, 0);
        check("pat drain mem_we",    mem_we,    0);
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        drain_frame("pat");
`else
        //               st len sv sd     rdy sr we b  d  v  data   sop eop
        // length=4, back-to-back, src_ready=1
        tbl.push_back(mk(1, 4, 0, 0,     1,  0, 0, 0, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 1, 'hA1,  1,  1, 1, 1, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 1, 'hA2,  1,  1, 1, 1, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 1, 'hA3,  1,  1, 1, 1, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 1, 'hA4,  1,  1, 1, 1, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1,  0, 0, 1, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1,  0, 0, 1, 0, 1, 'hA1,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1,  0, 0, 1, 0, 1, 'hA2,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1,  0, 0, 1, 0, 1, 'hA3,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1,  0, 0, 1, 0, 1, 'hA4,  0, 1));
        // done cycle: new start (length=3) accepted here
        tbl.push_back(mk(1, 3, 0, 0,     1,  0, 0, 0, 1, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 1, 'h10,  1,  1, 1, 1, 0, 0, 0,     0, 0));
        // start while busy is ignored
        tbl.push_back(mk(1, 7, 0, 0,     1,  1, 0, 1, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 1, 'h11,  1,  1, 1, 1, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1,  1, 0, 1, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 1, 'h12,  1,  1, 1, 1, 0, 0, 0,     0, 0));
        // DRAIN: snk_valid is not accepted, src_ready pattern 1,0,0,1,1
        tbl.push_back(mk(0, 0, 1, 'h99,  1,  0, 0, 1, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     0,  0, 0, 1, 0, 1, 'h10,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0,     0,  0, 0, 1, 0, 1, 'h10,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1,  0, 0, 1, 0, 1, 'h10,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1,  0, 0, 1, 0, 1, 'h11,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     1,  0, 0, 1, 0, 1, 'h12,  0, 1));
        // done cycle: zero-length start -> done next cycle, never busy
        tbl.push_back(mk(1, 0, 0, 0,     0,  0, 0, 0, 1, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     0,  0, 0, 0, 1, 0, 0,     0, 0));
        // length=1: single beat carries sop and eop, one stall cycle
        tbl.push_back(mk(1, 1, 0, 0,     0,  0, 0, 0, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 1, 'h5A,  0,  1, 1, 1, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     0,  0, 0, 1, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     0,  0, 0, 1, 0, 1, 'h5A,  1, 1));
        tbl.push_back(mk(0, 0, 0, 0,     1,  0, 0, 1, 0, 1, 'h5A,  1, 1));
        tbl.push_back(mk(0, 0, 0, 0,     0,  0, 0, 0, 1, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     0,  0, 0, 0, 0, 0, 0,     0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            start     = tbl[i].start;
            length    = tbl[i].length;
            snk_valid = tbl[i].snk_valid;
            snk_data  = tbl[i].snk_data;
            src_ready = tbl[i].src_ready;
            #1;
            check($sformatf("v%0d snk_ready", i), snk_ready, tbl[i].e_snk_ready);
            check($sformatf("v%0d mem_we", i),    mem_we,    tbl[i].e_we);
            check($sformatf("v%0d busy", i),      busy,      tbl[i].e_busy);
            check($sformatf("v%0d done", i),      done,      tbl[i].e_done);
            check($sformatf("v%0d src_valid", i), src_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                check($sformatf("v%0d src_data", i), src_data, tbl[i].e_data);
                check($sformatf("v%0d src_sop", i),  src_sop,  tbl[i].e_sop);
                check($sformatf("v%0d src_eop", i),  src_eop,  tbl[i].e_eop);
            end
        end
        start     = 1'b0;
        snk_valid = 1'b0;
        src_ready = 1'b0;

        // Reset while DRAIN holds a stalled beat: abort, no done pulse.
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h64};
        fill_frame("rst_mid");
        @(negedge clk);
        #1;
        check("rst_mid pre src_valid", src_valid, 1);
        check("rst_mid pre busy",      busy,      1);
        reset_n = 1'b0;
        #1;
        check_reset("rst_mid");
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("post_rst c%0d done", k),      done,      0);
            check($sformatf("post_rst c%0d busy", k),      busy,      0);
            check($sformatf("post_rst c%0d src_valid", k), src_valid, 0);
        end

        // Normal frame after the abort.
        exp_q = '{8'h33, 8'h44};
        fill_frame("len2");
        drain_frame("len2");

        // Full-depth frame: every address used, eop only on the last beat.
        exp_q.delete();
        for (int k = 0; k < (1 << AW); k++) exp_q.push_back(DW'(k + (k >> 8) * 64));
        fill_frame("full");
        drain_frame("full");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
